// File: rtl/bsk_prd_poller.sv
// bsk_prd_poller: host-side bus master for the PRD command board.
// Polls board registers 0, 1 and 3 over the 16-bit parallel bus, checks the
// nibble/complement encoding and the password, and publishes a clean command
// word with error flags. The default build only reads from the board.
// Define BSK_POLL_WRITE_EN to add the WR2/WR3 accesses, which write the
// indication word and the test-enable bit back to the board.
module bsk_prd_poller #(
  parameter logic [3:0] CS         = 4'b1011,
  parameter logic [7:0] PASSWORD   = 8'hA4,
  parameter int         STROBE_LEN = 2,
  parameter int         POLL_GAP   = 16
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        en,
  inout  wire  [15:0] bD,
  output logic [1:0]  oA,
  output logic [3:0]  oCS,
  output logic        oRd,
  output logic        oWr,
  input  logic [15:0] iInd,
  input  logic        iTestEn,
  output logic [15:0] oCom,
  output logic        oComValid,
  output logic [2:0]  oErr,
  output logic [6:0]  oVersion,
  output logic        oTestEnRb,
  output logic        oBusy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD3  = 3'd3,
    WR2  = 3'd4,
    WR3  = 3'd5,
    DONE = 3'd6
  } state_t;

  // Phase numbering inside an access: 0 = SETUP, 1..STROBE_LEN = STROBE,
  // STROBE_LEN+1 = HOLD.
  localparam logic [4:0] STROBE_LAST = 5'(STROBE_LEN);
  localparam logic [4:0] HOLD_PH     = 5'(STROBE_LEN + 1);
  localparam logic [7:0] GAP_LAST    = 8'(POLL_GAP - 1);

  state_t      r_state;
  state_t      w_stateNext;
  logic [4:0]  r_phase;
  logic [4:0]  w_phaseNext;
  logic [7:0]  r_gap;
  logic [7:0]  w_gapNext;
  logic        w_pollStart;

  logic        w_readNext;
  logic        w_writeNext;
  logic        w_accessNext;
  logic        w_strobeNext;
  logic [1:0]  w_addrNext;

  logic [15:0] r_word0;
  logic [15:0] r_word1;
  logic [15:0] r_word3;
  logic [15:0] w_com;
  logic [2:0]  w_flags;
  logic        w_enterDone;

  // A byte is well formed when its high nibble is the complement of its low nibble.
  function automatic logic byteOk(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

  // State, phase and gap-counter registers; aclr drops any partial poll.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_phase <= w_phaseNext;
      r_gap   <= w_gapNext;
    end
  end

  // Next-state logic: gap counting in IDLE, phase stepping inside each access.
  always_comb begin
    w_stateNext = r_state;
    w_phaseNext = r_phase;
    w_gapNext   = r_gap;
    w_pollStart = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_gap == GAP_LAST) begin
          if (en) begin
            w_stateNext = RD0;
            w_phaseNext = '0;
            w_gapNext   = '0;
            w_pollStart = 1'b1;
          end
        end else begin
          w_gapNext = r_gap + 8'd1;
        end
      end
      RD0, RD1, RD3, WR2, WR3: begin
        if (r_phase == HOLD_PH) begin
          w_phaseNext = '0;
          case (r_state)
            RD0:     w_stateNext = RD1;
            RD1:     w_stateNext = RD3;
`ifdef BSK_POLL_WRITE_EN
            RD3:     w_stateNext = WR2;
            WR2:     w_stateNext = WR3;
`else
            RD3:     w_stateNext = DONE;
`endif
            default: w_stateNext = DONE;
          endcase
        end else begin
          w_phaseNext = r_phase + 5'd1;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
        w_phaseNext = '0;
        w_gapNext   = '0;
      end
      default: begin
        w_stateNext = IDLE;
        w_phaseNext = '0;
        w_gapNext   = '0;
      end
    endcase
  end

  // Bus-control decode of the upcoming clk, so the pins can be registered glitch-free.
  always_comb begin
    w_readNext  = 1'b0;
    w_writeNext = 1'b0;
    w_addrNext  = 2'd0;
    case (w_stateNext)
      RD0: begin
        w_readNext = 1'b1;
        w_addrNext = 2'd0;
      end
      RD1: begin
        w_readNext = 1'b1;
        w_addrNext = 2'd1;
      end
      RD3: begin
        w_readNext = 1'b1;
        w_addrNext = 2'd3;
      end
`ifdef BSK_POLL_WRITE_EN
      WR2: begin
        w_writeNext = 1'b1;
        w_addrNext  = 2'd2;
      end
      WR3: begin
        w_writeNext = 1'b1;
        w_addrNext  = 2'd3;
      end
`endif
      default: begin
        w_readNext  = 1'b0;
        w_writeNext = 1'b0;
        w_addrNext  = 2'd0;
      end
    endcase
    w_accessNext = w_readNext | w_writeNext;
    w_strobeNext = w_accessNext && (w_phaseNext >= 5'd1) && (w_phaseNext <= STROBE_LAST);
  end

  // Registered bus pins; address and select change only on SETUP entry, strobes only inside the access.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      oA    <= 2'd0;
      oCS   <= 4'hF;
      oRd   <= 1'b1;
      oBusy <= 1'b0;
    end else begin
      oA    <= w_addrNext;
      oCS   <= w_accessNext ? CS : 4'hF;
      oRd   <= ~(w_readNext && w_strobeNext);
      oBusy <= (w_stateNext != IDLE);
    end
  end

  // Capture the read data on the last strobe clk of each read access.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_word0 <= '0;
      r_word1 <= '0;
      r_word3 <= '0;
    end else if (r_phase == STROBE_LAST) begin
      case (r_state)
        RD0:     r_word0 <= bD;
        RD1:     r_word1 <= bD;
        RD3:     r_word3 <= bD;
        default: r_word0 <= r_word0;
      endcase
    end
  end

`ifdef BSK_POLL_WRITE_EN
  logic [15:0] r_indSnap;
  logic        r_teSnap;
  logic [15:0] r_wdata;
  logic        r_drive;
  logic        r_wrN;

  // Snapshot the write-back values when the poll starts so they stay stable for WR2/WR3.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_indSnap <= '0;
      r_teSnap  <= 1'b0;
    end else if (w_pollStart) begin
      r_indSnap <= iInd;
      r_teSnap  <= iTestEn;
    end
  end

  // Write strobe and data-bus driver; the bus is driven from SETUP through HOLD of a write.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_wrN   <= 1'b1;
      r_drive <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_wrN   <= ~(w_writeNext && w_strobeNext);
      r_drive <= w_writeNext;
      r_wdata <= (w_stateNext == WR2) ? r_indSnap : {15'b0, r_teSnap};
    end
  end

  assign oWr = r_wrN;
  assign bD  = r_drive ? r_wdata : 16'hzzzz;
`else
  logic w_unusedWriteInputs;

  assign w_unusedWriteInputs = ^{iInd, iTestEn};
  assign oWr = 1'b1;
  assign bD  = 16'hzzzz;
`endif

  assign w_com = {r_word1[11:8], r_word1[3:0], r_word0[11:8], r_word0[3:0]};
  assign w_flags[0] = ~(byteOk(r_word0[7:0]) & byteOk(r_word0[15:8]));
  assign w_flags[1] = ~(byteOk(r_word1[7:0]) & byteOk(r_word1[15:8]));
  assign w_flags[2] = (r_word3[15:8] != PASSWORD);
  assign w_enterDone = (w_stateNext == DONE) && (r_state != DONE);

  // Publish the poll result on the edge that enters DONE; the command word only when everything checks out.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      oCom      <= '0;
      oComValid <= 1'b0;
      oErr      <= '0;
      oVersion  <= '0;
      oTestEnRb <= 1'b0;
    end else begin
      oComValid <= 1'b0;
      if (w_enterDone) begin
        oErr      <= w_flags;
        oVersion  <= r_word3[7:1];
        oTestEnRb <= r_word3[0];
        if (w_flags == 3'b000) begin
          oCom      <= w_com;
          oComValid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bsk_prd_poller.sv
// tb_bsk_prd_poller: self-checking bench for bsk_prd_poller with a PRD board model.
// The bus carries a pull-up, so a released bus reads 16'hFFFF.
// Honours BSK_POLL_WRITE_EN to expect the write-back accesses.
module tb_bsk_prd_poller;

  localparam int         STROBE_LEN = 2;
  localparam int         POLL_GAP   = 16;
  localparam logic [3:0] BOARD_CS   = 4'b1011;
`ifdef BSK_POLL_WRITE_EN
  localparam int         ACCESSES   = 5;
  localparam int         WR_LOW     = 2 * STROBE_LEN;
`else
  localparam int         ACCESSES   = 3;
  localparam int         WR_LOW     = 0;
`endif
  localparam int         POLL_LEN   = ACCESSES * (STROBE_LEN + 2) + 1;

  logic        clk = 1'b0;
  logic        aclr;
  logic        en;
  tri1  [15:0] bD;
  logic [1:0]  oA;
  logic [3:0]  oCS;
  logic        oRd;
  logic        oWr;
  logic [15:0] iInd;
  logic        iTestEn;
  logic [15:0] oCom;
  logic        oComValid;
  logic [2:0]  oErr;
  logic [6:0]  oVersion;
  logic        oTestEnRb;
  logic        oBusy;

  // Board model storage; bit 0 of address 3 is owned by the board and written by the host.
  logic [15:0] board0;
  logic [15:0] board1;
  logic [15:1] board3Hi;
  logic        boardTe = 1'b1;
  logic [15:0] boardRd;
  logic [15:0] capInd = 16'h0;
  logic        capTe = 1'b0;
  int          capCnt2 = 0;
  int          capCnt3 = 0;

  // Reference model state.
  logic [15:0] modelCom;
  logic        modelTe;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [15:0] com;
    logic [2:0]  err;
    logic [6:0]  ver;
    logic        te;
  } expect_t;

  bsk_prd_poller #(
    .CS(BOARD_CS), .PASSWORD(8'hA4), .STROBE_LEN(STROBE_LEN), .POLL_GAP(POLL_GAP)
  ) dut (
    .clk(clk), .aclr(aclr), .en(en), .bD(bD), .oA(oA), .oCS(oCS), .oRd(oRd), .oWr(oWr),
    .iInd(iInd), .iTestEn(iTestEn), .oCom(oCom), .oComValid(oComValid), .oErr(oErr),
    .oVersion(oVersion), .oTestEnRb(oTestEnRb), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  // Board read mux: returns the addressed register while selected and the read strobe is low.
  always_comb begin
    boardRd = 16'h0000;
    case (oA)
      2'd0:    boardRd = board0;
      2'd1:    boardRd = board1;
      2'd3:    boardRd = {board3Hi, boardTe};
      default: boardRd = 16'h0000;
    endcase
  end

  assign bD = (oCS == BOARD_CS && oRd == 1'b0) ? boardRd : 16'hzzzz;

  // Board write latch on the rising edge of the write strobe.
  always @(posedge oWr) begin
    if (oCS == BOARD_CS) begin
      if (oA == 2'd2) begin
        capInd  <= bD;
        capCnt2 <= capCnt2 + 1;
      end else if (oA == 2'd3) begin
        boardTe <= bD[0];
        capTe   <= bD[0];
        capCnt3 <= capCnt3 + 1;
      end
    end
  end

  function automatic bit byteValid(input int b);
    return (((b >> 4) & 15) + (b & 15)) == 15;
  endfunction

  // Expected poll result computed arithmetically from the three words read.
  function automatic expect_t refModel(input int w0, input int w1, input int w3);
    expect_t e;
    e.com    = 16'((w0 & 15) | (((w0 >> 8) & 15) << 4) | ((w1 & 15) << 8) | (((w1 >> 8) & 15) << 12));
    e.err[0] = !(byteValid(w0 & 255) && byteValid((w0 >> 8) & 255));
    e.err[1] = !(byteValid(w1 & 255) && byteValid((w1 >> 8) & 255));
    e.err[2] = ((w3 >> 8) & 255) != 164;
    e.ver    = 7'((w3 >> 1) & 127);
    e.te     = 1'(w3 & 1);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w3,
                               input logic [15:0] ind, input logic te);
    board0   = w0;
    board1   = w1;
    board3Hi = w3[15:1];
    iInd     = ind;
    iTestEn  = te;
  endtask

  // Waits for the next poll, measures it and compares the results with the model.
  task automatic runPoll(input bit checkGap, input int dropEnAt);
    expect_t e;
    int idle = 0;
    int len = 0;
    int vcnt = 0;
    int rdLow = 0;
    int wrLow = 0;
    int c2;
    int c3;
    e  = refModel(int'(board0), int'(board1), int'({board3Hi, modelTe}));
    c2 = capCnt2;
    c3 = capCnt3;
    while (!oBusy && idle < 4 * POLL_GAP + 50) begin
      idle++;
      @(negedge clk);
    end
    checkOutput("pollStart", 32'(oBusy), 32'd1);
    if (checkGap) checkOutput("pollGap", 32'(idle), 32'(POLL_GAP));
    while (oBusy && len < 200) begin
      len++;
      if (oComValid) vcnt++;
      if (!oRd) rdLow++;
      if (!oWr) wrLow++;
      if (len == dropEnAt) en = 1'b0;
      @(negedge clk);
    end
    if (e.err == 3'b000) modelCom = e.com;
    checkOutput("pollLen", 32'(len), 32'(POLL_LEN));
    checkOutput("rdStrobeClks", 32'(rdLow), 32'(3 * STROBE_LEN));
    checkOutput("wrStrobeClks", 32'(wrLow), 32'(WR_LOW));
    checkOutput("validPulses", 32'(vcnt), (e.err == 3'b000) ? 32'd1 : 32'd0);
    checkOutput("validAfter", 32'(oComValid), 32'd0);
    checkOutput("oCom", 32'(oCom), 32'(modelCom));
    checkOutput("oErr", 32'(oErr), 32'(e.err));
    checkOutput("oVersion", 32'(oVersion), 32'(e.ver));
    checkOutput("oTestEnRb", 32'(oTestEnRb), 32'(e.te));
    checkOutput("busReleased", 32'(bD), 32'hFFFF);
`ifdef BSK_POLL_WRITE_EN
    checkOutput("wr2Count", 32'(capCnt2), 32'(c2 + 1));
    checkOutput("wr2Data", 32'(capInd), 32'(iInd));
    checkOutput("wr3Count", 32'(capCnt3), 32'(c3 + 1));
    checkOutput("wr3Bit", 32'(capTe), 32'(iTestEn));
    modelTe = iTestEn;
`else
    checkOutput("wr2Count", 32'(capCnt2), 32'(c2));
    checkOutput("wr3Count", 32'(capCnt3), 32'(c3));
`endif
  endtask

  initial begin
    logic [15:0] c;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w3;
    logic [7:0]  pw;
    int          mode;
    int          extra;

    aclr     = 1'b1;
    en       = 1'b0;
    modelCom = 16'h0000;
    modelTe  = 1'b1;
    applyStimulus(16'hC3B4, 16'hE1D2, 16'hA44B, 16'h0000, 1'b1);

    // Reset values while aclr is held.
    repeat (3) @(negedge clk);
    checkOutput("rstRd", 32'(oRd), 32'd1);
    checkOutput("rstWr", 32'(oWr), 32'd1);
    checkOutput("rstCS", 32'(oCS), 32'hF);
    checkOutput("rstA", 32'(oA), 32'd0);
    checkOutput("rstBus", 32'(bD), 32'hFFFF);
    checkOutput("rstCom", 32'(oCom), 32'd0);
    checkOutput("rstValid", 32'(oComValid), 32'd0);
    checkOutput("rstErr", 32'(oErr), 32'd0);
    checkOutput("rstVersion", 32'(oVersion), 32'd0);
    checkOutput("rstTestEnRb", 32'(oTestEnRb), 32'd0);
    checkOutput("rstBusy", 32'(oBusy), 32'd0);
    aclr = 1'b0;
    en   = 1'b1;

    // Directed: clean poll, corrupted word1, wrong password, write-back.
    runPoll(1'b1, 0);
    applyStimulus(16'hC3B4, 16'hE1D3, 16'hA44B, 16'h0000, 1'b1);
    runPoll(1'b1, 0);
    applyStimulus(16'hC3B4, 16'hE1D2, 16'h5A4B, 16'h0000, 1'b1);
    runPoll(1'b1, 0);
    applyStimulus(16'hC3B4, 16'hE1D2, 16'hA44B, 16'h00FF, 1'b1);
    runPoll(1'b1, 0);
    applyStimulus(16'hC3B4, 16'hE1D2, 16'hA44B, 16'h0000, 1'b0);
    runPoll(1'b1, 0);

    // Randomized polls: valid words, single-bit corruption in either word, or a bad password.
    for (int i = 0; i < 10; i++) begin
      c    = 16'($urandom);
      mode = int'($urandom_range(0, 3));
      w0   = {~c[7:4], c[7:4], ~c[3:0], c[3:0]};
      w1   = {~c[15:12], c[15:12], ~c[11:8], c[11:8]};
      w3   = {8'hA4, 7'($urandom), 1'b0};
      if (mode == 1) w0 = w0 ^ (16'h0001 << $urandom_range(0, 15));
      if (mode == 2) w1 = w1 ^ (16'h0001 << $urandom_range(0, 15));
      if (mode == 3) begin
        pw = 8'($urandom);
        if (pw == 8'hA4) pw = 8'h00;
        w3[15:8] = pw;
      end
      applyStimulus(w0, w1, w3, 16'($urandom), 1'($urandom));
      runPoll(1'b1, 0);
    end

    // Dropping en mid-poll finishes that poll and starts no other.
    applyStimulus(16'h5AF0, 16'h9669, 16'hA4FE, 16'hBEEF, 1'b1);
    runPoll(1'b1, 5);
    extra = 0;
    repeat (3 * POLL_GAP) begin
      @(negedge clk);
      if (oBusy) extra++;
    end
    checkOutput("noRestart", 32'(extra), 32'd0);

    // aclr in the second strobe clk of RD1 aborts the poll at once.
    applyStimulus(16'hC3B4, 16'hE1D2, 16'hA44B, 16'h1111, 1'b1);
    en = 1'b1;
    extra = 0;
    while (!oBusy && extra < 4 * POLL_GAP) begin
      extra++;
      @(negedge clk);
    end
    checkOutput("abortPollStart", 32'(oBusy), 32'd1);
    repeat (STROBE_LEN + 4) @(negedge clk);
    checkOutput("rd1Strobe", 32'(oRd), 32'd0);
    checkOutput("rd1Addr", 32'(oA), 32'd1);
    aclr = 1'b1;
    #1;
    checkOutput("abortRd", 32'(oRd), 32'd1);
    checkOutput("abortCS", 32'(oCS), 32'hF);
    checkOutput("abortBus", 32'(bD), 32'hFFFF);
    checkOutput("abortBusy", 32'(oBusy), 32'd0);
    checkOutput("abortValid", 32'(oComValid), 32'd0);
    checkOutput("abortCom", 32'(oCom), 32'd0);
    modelCom = 16'h0000;
    @(negedge clk);
    aclr = 1'b0;
    runPoll(1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsk_prd_poller.md
# bsk_prd_poller

Host-side bus master for the PRD command board's 16-bit parallel bus. It polls the board's registers cyclically and validates the nibble/complement command encoding and the password. It outputs a clean 16-bit command word with error flags, and writes back the indication word and the test-enable bit. It sits on the controller side, driving the chip-select, address and strobe lines that the PRD board decodes.

## Interface
- CS, 4'b1011, board address driven on oCS during an access
- PASSWORD, 8'hA4, expected value of read-address 3 bits [15:8]
- STROBE_LEN, 2, oRd/oWr low width in clk cycles (1..15)
- POLL_GAP, 16, idle clk cycles between polls (1..255)

Ports:
- clk  in  1  system clock
- aclr  in  1  reset, asynchronous, active-high
- en  in  1  polling enable, sampled only in IDLE
- bD  inout  16  data bus; driven only during write accesses, else Z
- oA  out  2  register address
- oCS  out  4  chip select; CS during an access, 4'hF otherwise
- oRd  out  1  read strobe, active low
- oWr  out  1  write strobe, active low
- iInd  in  16  indication word to write to address 2
- iTestEn  in  1  test-enable bit to write to address 3 bit 0
- oCom  out  16  last validated command word
- oComValid  out  1  one-clk pulse when oCom is updated
- oErr  out  3  [0] word0 encoding error, [1] word1 encoding error, [2] password mismatch
- oVersion  out  7  address-3 bits [7:1] from the last poll
- oTestEnRb  out  1  address-3 bit 0 from the last poll
- oBusy  out  1  high from the first SETUP clk to DONE inclusive

## Operation
- FSM states: IDLE, RD0, RD1, RD3, WR2, WR3, DONE.
- Transition order: IDLE → RD0 → RD1 → RD3 → WR2 → WR3 → DONE → IDLE.
- IDLE: the gap counter counts POLL_GAP clks. The poll starts at the first clk after that with en=1.
- At poll start, iInd and iTestEn are snapshotted. Writes use the snapshot.
- Each access state has three phases: SETUP (1 clk), STROBE (STROBE_LEN clks), HOLD (1 clk).
  - oA and oCS are valid for all three phases.
  - The strobe is low only during STROBE.
- Read accesses:
  - bD is Z throughout.
  - Data is sampled on the last STROBE clk.
- Write accesses:
  - bD is driven from SETUP through HOLD. WR2 drives the iInd snapshot; WR3 drives {15'b0, snapshot test-enable}.
  - The board latches on the oWr rising edge, which is the STROBE→HOLD boundary.
- Decoding: each byte is valid iff byte[7:4] == ~byte[3:0].
  - Word0 gives com[3:0] = b0[3:0] and com[7:4] = b1[3:0].
  - Word1 gives com[11:8] and com[15:12] the same way.
- Password: RD3 data[15:8] == PASSWORD. oVersion and oTestEnRb are updated in DONE regardless of the check.
- DONE (1 clk):
  - oErr is updated with this poll's flags.
  - If all flags are 0, oCom loads the new word and oComValid pulses.
  - Otherwise oCom holds its previous value and there is no pulse.
- Deasserting en mid-poll completes the current poll; no further poll starts.

## Timing
- Reset values:
  - oRd=1, oWr=1, oCS=4'hF, oA=0, bD=Z.
  - oCom=0, oComValid=0, oErr=0, oVersion=0, oTestEnRb=0, oBusy=0.
  - FSM in IDLE with the gap counter cleared.
- aclr during any state: outputs go to the reset values asynchronously, including immediate strobe release and bD=Z. The partial poll is discarded.
- Access length is STROBE_LEN+2 clks; the default is 4.
- Full poll is 5·(STROBE_LEN+2)+1 clks; the default is 21.
- Poll period with en held high is poll length + POLL_GAP; the default is 37.
- oComValid is asserted in the DONE clk. oCom is updated on the same clk edge.
- The strobe never toggles in the same clk as an oA/oCS change.

## Configuration
- BSK_POLL_WRITE_EN defined: WR2 and WR3 are compiled in. The poll is as above.
- Not defined:
  - WR2 and WR3 are removed, so RD3 → DONE directly.
  - oWr is constantly 1 and bD is never driven.
  - iInd and iTestEn are ignored.
  - The default poll is 13 clks.

## Test plan
- Reset: hold aclr for 3 clks → every output equals its reset value and bD is Z.
- Board model with iCom=16'h1234:
  - Reads return word0=16'hC3B4, word1=16'hE1D2 and addr3=16'hA44B (version 7'h25, test_en 1).
  - Required: oCom=16'h1234, a one-clk oComValid pulse, oErr=0, oVersion=7'h25, oTestEnRb=1.
- Word1 corrupted to 16'hE1D3 → oErr=3'b010, oCom holds 16'h1234, no oComValid pulse.
- Address 3 returns 16'h5A4B → oErr=3'b100, oCom unchanged, oVersion=7'h25.
- iInd=16'h00FF, iTestEn=1 (macro defined):
  - The model captures 16'h00FF at address 2 and bit0=1 at address 3 on the oWr rising edges.
  - The next poll gives oTestEnRb=1.
  - With the macro undefined, oWr stays 1 for the whole poll.
- aclr pulsed in the second STROBE clk of RD1 → oRd=1 and bD=Z immediately, no oComValid pulse. After release, the poll restarts from RD0 following POLL_GAP.
